// File: rtl/pl_led_pattern.sv
// rtl/pl_led_pattern.sv - LED pattern generator with blink, run, bounce and PWM breathe modes
//
// Purpose: drives LED_NUM LEDs with one of four patterns. A step counter
// paces BLINK/RUN/BOUNCE. BREATHE uses a free-running PWM counter whose
// duty ramps up and down.
//
// Ports:
//   sys_clk    in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = run, 0 = freeze counters, pattern and outputs
//   mode       in   00 BLINK, 01 RUN, 10 BOUNCE, 11 BREATHE
//   pl_led     out  LED drive (1 = on), registered
//   step_pulse out  one-cycle strobe on each step boundary, registered

module pl_led_pattern #(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int PWM_BITS    = 8,
  parameter int DUTY_DIV    = 98
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] pl_led,
  output logic               step_pulse
);

  localparam logic [1:0] MODE_BLINK   = 2'b00;
  localparam logic [1:0] MODE_RUN     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  localparam int SCW = $clog2(STEP_CYCLES);
  localparam int DCW = (DUTY_DIV > 1) ? $clog2(DUTY_DIV) : 1;
  localparam int PW  = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_CYCLES - 1);
  localparam logic [DCW-1:0]      DIV_LAST  = DCW'(DUTY_DIV - 1);
  localparam logic [PW-1:0]       POS_LAST  = PW'(LED_NUM - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};

  logic [1:0]          mode_q;
  // Cleared by reset: the stored mode is treated as equal to the live mode
  // until the first edge, so coming out of reset is never a mode change.
  logic                mode_vld;
  logic [SCW-1:0]      step_cnt, step_cnt_nx;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nx;
  logic [DCW-1:0]      div_cnt, div_nx;
  logic [PWM_BITS-1:0] duty, duty_nx;
  logic                duty_dn, duty_dn_nx;
  logic [PW-1:0]       pos, pos_nx;
  logic                dir_dn, dir_dn_nx;
  logic                lvl, lvl_nx;
  logic                pulse_nx;
  logic                reload;
  logic                led_upd;

  assign reload  = mode_vld && (mode != mode_q);
  // LEDs follow state on enabled edges, on reloads, and once right after
  // reset so RUN/BOUNCE show their initial LED even while disabled.
  assign led_upd = reload || enable || !mode_vld;

  function automatic logic [LED_NUM-1:0] led_view(
    input logic [1:0]          m,
    input logic                l,
    input logic [PW-1:0]       p,
    input logic [PWM_BITS-1:0] pc,
    input logic [PWM_BITS-1:0] d
  );
    logic [LED_NUM-1:0] v;
    v = '0;
    case (m)
      MODE_BLINK:              v = {LED_NUM{l}};
      MODE_RUN, MODE_BOUNCE:   v[p] = 1'b1;
      default:                 v = {LED_NUM{pc < d}};
    endcase
    return v;
  endfunction

  always_comb begin
    step_cnt_nx = step_cnt;
    pwm_nx      = pwm_cnt;
    div_nx      = div_cnt;
    duty_nx     = duty;
    duty_dn_nx  = duty_dn;
    pos_nx      = pos;
    dir_dn_nx   = dir_dn;
    lvl_nx      = lvl;
    pulse_nx    = 1'b0;

    if (reload) begin
      // Reload beats a coinciding step boundary: everything back to start.
      step_cnt_nx = '0;
      pwm_nx      = '0;
      div_nx      = '0;
      duty_nx     = '0;
      duty_dn_nx  = 1'b0;
      pos_nx      = '0;
      dir_dn_nx   = 1'b0;
      lvl_nx      = 1'b0;
    end else if (enable) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt_nx = '0;
        pulse_nx    = 1'b1;
        case (mode)
          MODE_BLINK: lvl_nx = ~lvl;
          MODE_RUN:   pos_nx = (pos == POS_LAST) ? '0 : pos + 1'b1;
          MODE_BOUNCE: begin
            // Ends are shown for one step: the turn happens while leaving them.
            if (LED_NUM > 1) begin
              if (!dir_dn) begin
                if (pos == POS_LAST) begin
                  dir_dn_nx = 1'b1;
                  pos_nx    = pos - 1'b1;
                end else begin
                  pos_nx = pos + 1'b1;
                end
              end else begin
                if (pos == '0) begin
                  dir_dn_nx = 1'b0;
                  pos_nx    = pos + 1'b1;
                end else begin
                  pos_nx = pos - 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end else begin
        step_cnt_nx = step_cnt + 1'b1;
      end

      pwm_nx = pwm_cnt + 1'b1;
      if (pwm_cnt == PWM_MAX) begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          // Turn around at the ends so the duty never wraps.
          if (!duty_dn) begin
            if (duty == PWM_MAX) begin
              duty_dn_nx = 1'b1;
              duty_nx    = duty - 1'b1;
            end else begin
              duty_nx = duty + 1'b1;
            end
          end else begin
            if (duty == '0) begin
              duty_dn_nx = 1'b0;
              duty_nx    = duty + 1'b1;
            end else begin
              duty_nx = duty - 1'b1;
            end
          end
        end else begin
          div_nx = div_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_BLINK;
      mode_vld   <= 1'b0;
      step_cnt   <= '0;
      pwm_cnt    <= '0;
      div_cnt    <= '0;
      duty       <= '0;
      duty_dn    <= 1'b0;
      pos        <= '0;
      dir_dn     <= 1'b0;
      lvl        <= 1'b0;
      step_pulse <= 1'b0;
      pl_led     <= '0;
    end else begin
      mode_q     <= mode;
      mode_vld   <= 1'b1;
      step_cnt   <= step_cnt_nx;
      pwm_cnt    <= pwm_nx;
      div_cnt    <= div_nx;
      duty       <= duty_nx;
      duty_dn    <= duty_dn_nx;
      pos        <= pos_nx;
      dir_dn     <= dir_dn_nx;
      lvl        <= lvl_nx;
      step_pulse <= pulse_nx;
      if (led_upd) begin
        pl_led <= led_view(mode, lvl_nx, pos_nx, pwm_nx, duty_nx);
      end
    end
  end

endmodule

// File: tb/tb_pl_led_pattern.sv
// tb/tb_pl_led_pattern.sv - directed self-checking bench for pl_led_pattern

module tb_pl_led_pattern;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] pl_led;
  logic       step_pulse;

  int n_vec = 0;
  int n_err = 0;

  pl_led_pattern #(
    .LED_NUM(4), .STEP_CYCLES(4), .PWM_BITS(2), .DUTY_DIV(1)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .pl_led(pl_led), .step_pulse(step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; mode = 2'b00;
    tick(); tick();
    n_vec++;
    if (pl_led !== 4'b0000) begin n_err++; $display("FAIL reset_led: got %b want 0000", pl_led); end
    n_vec++;
    if (step_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", step_pulse); end
    rst_n = 1'b1;
  endtask

  task automatic test_blink();
    logic [3:0] exp_led;
    logic       exp_p;
    exp_led = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_p = (i % 4 == 0);
      if (exp_p) exp_led = ~exp_led;
      n_vec++;
      if (step_pulse !== exp_p) begin n_err++; $display("FAIL blink_pulse edge%0d: got %b want %b", i, step_pulse, exp_p); end
      n_vec++;
      if (pl_led !== exp_led) begin n_err++; $display("FAIL blink_led edge%0d: got %b want %b", i, pl_led, exp_led); end
    end
  endtask

  task automatic test_run();
    logic [3:0] tbl [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_led;
    mode = 2'b01;
    tick();
    exp_led = 4'b0001;
    n_vec++;
    if (pl_led !== exp_led || step_pulse !== 1'b0) begin n_err++; $display("FAIL run_reload: got %b/%b want 0001/0", pl_led, step_pulse); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i % 4 == 0) exp_led = tbl[i/4 - 1];
      n_vec++;
      if (step_pulse !== (i % 4 == 0)) begin n_err++; $display("FAIL run_pulse edge%0d: got %b want %b", i, step_pulse, (i % 4 == 0)); end
      n_vec++;
      if (pl_led !== exp_led) begin n_err++; $display("FAIL run_led edge%0d: got %b want %b", i, pl_led, exp_led); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] tbl [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] exp_led;
    mode = 2'b10;
    tick();
    exp_led = 4'b0001;
    n_vec++;
    if (pl_led !== exp_led || step_pulse !== 1'b0) begin n_err++; $display("FAIL bounce_reload: got %b/%b want 0001/0", pl_led, step_pulse); end
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (i % 4 == 0) exp_led = tbl[i/4 - 1];
      n_vec++;
      if (step_pulse !== (i % 4 == 0)) begin n_err++; $display("FAIL bounce_pulse edge%0d: got %b want %b", i, step_pulse, (i % 4 == 0)); end
      n_vec++;
      if (pl_led !== exp_led) begin n_err++; $display("FAIL bounce_led edge%0d: got %b want %b", i, pl_led, exp_led); end
    end
  endtask

  task automatic test_breathe();
    int exp_on [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int on;
    int pulses;
    pulses = 0;
    mode = 2'b11;
    tick();
    n_vec++;
    if (pl_led !== 4'b0000 || step_pulse !== 1'b0) begin n_err++; $display("FAIL breathe_reload: got %b/%b want 0000/0", pl_led, step_pulse); end
    for (int per = 0; per < 8; per++) begin
      on = 0;
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (pl_led !== 4'b0000 && pl_led !== 4'b1111) begin n_err++; $display("FAIL breathe_uniform per%0d: got %b want 0000 or 1111", per, pl_led); end
        if (pl_led[0]) on++;
        tick();
        if (step_pulse) pulses++;
      end
      n_vec++;
      if (on != exp_on[per]) begin n_err++; $display("FAIL breathe_on per%0d: got %0d want %0d", per, on, exp_on[per]); end
    end
    n_vec++;
    if (pulses != 8) begin n_err++; $display("FAIL breathe_pulses: got %0d want 8", pulses); end
  endtask

  task automatic test_step_switch();
    mode = 2'b01;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== 1'b0 || pl_led !== 4'b0001) begin n_err++; $display("FAIL switch_pre edge%0d: got %b/%b want 0001/0", i, pl_led, step_pulse); end
    end
    mode = 2'b10;
    tick();
    n_vec++;
    if (step_pulse !== 1'b0) begin n_err++; $display("FAIL switch_pulse: got %b want 0", step_pulse); end
    n_vec++;
    if (pl_led !== 4'b0001) begin n_err++; $display("FAIL switch_led: got %b want 0001", pl_led); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== (i == 4)) begin n_err++; $display("FAIL switch_next edge%0d: got %b want %b", i, step_pulse, (i == 4)); end
    end
    n_vec++;
    if (pl_led !== 4'b0010) begin n_err++; $display("FAIL switch_after_led: got %b want 0010", pl_led); end
  endtask

  task automatic test_freeze();
    mode = 2'b01;
    tick();
    repeat (4) tick();
    n_vec++;
    if (step_pulse !== 1'b1 || pl_led !== 4'b0010) begin n_err++; $display("FAIL freeze_setup: got %b/%b want 0010/1", pl_led, step_pulse); end
    tick();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== 1'b0 || pl_led !== 4'b0010) begin n_err++; $display("FAIL freeze_hold cyc%0d: got %b/%b want 0010/0", i, pl_led, step_pulse); end
    end
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== (i == 3)) begin n_err++; $display("FAIL freeze_resume edge%0d: got %b want %b", i, step_pulse, (i == 3)); end
    end
    n_vec++;
    if (pl_led !== 4'b0100) begin n_err++; $display("FAIL freeze_resume_led: got %b want 0100", pl_led); end
  endtask

  task automatic test_disabled_mode_change();
    enable = 1'b0;
    mode   = 2'b00;
    tick();
    n_vec++;
    if (pl_led !== 4'b0000 || step_pulse !== 1'b0) begin n_err++; $display("FAIL dis_reload_blink: got %b/%b want 0000/0", pl_led, step_pulse); end
    repeat (3) tick();
    n_vec++;
    if (pl_led !== 4'b0000 || step_pulse !== 1'b0) begin n_err++; $display("FAIL dis_frozen: got %b/%b want 0000/0", pl_led, step_pulse); end
    mode = 2'b01;
    tick();
    n_vec++;
    if (pl_led !== 4'b0001) begin n_err++; $display("FAIL dis_reload_run: got %b want 0001", pl_led); end
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== (i == 4)) begin n_err++; $display("FAIL dis_resume edge%0d: got %b want %b", i, step_pulse, (i == 4)); end
    end
    n_vec++;
    if (pl_led !== 4'b0010) begin n_err++; $display("FAIL dis_resume_led: got %b want 0010", pl_led); end
  endtask

  task automatic test_async_reset();
    repeat (4) tick();
    tick();
    n_vec++;
    if (pl_led !== 4'b0100) begin n_err++; $display("FAIL areset_setup: got %b want 0100", pl_led); end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (pl_led !== 4'b0000) begin n_err++; $display("FAIL areset_led: got %b want 0000", pl_led); end
    n_vec++;
    if (step_pulse !== 1'b0) begin n_err++; $display("FAIL areset_pulse: got %b want 0", step_pulse); end
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_vec++;
      if (step_pulse !== (i == 4)) begin n_err++; $display("FAIL areset_pulse edge%0d: got %b want %b", i, step_pulse, (i == 4)); end
      n_vec++;
      if (pl_led !== ((i == 4) ? 4'b0010 : 4'b0001)) begin n_err++; $display("FAIL areset_led edge%0d: got %b want %b", i, pl_led, ((i == 4) ? 4'b0010 : 4'b0001)); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_run();
    test_bounce();
    test_breathe();
    test_step_switch();
    test_freeze();
    test_disabled_mode_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
